coalescing_write_buffer: RTL
============================

COALESCING_WRITE_BUFFER -- requirements
Module: coalescing_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entry count (power of two, >=2).
REQ-002 SHALL have parameter AW, default 30, word-address width.
REQ-003 SHALL have parameter DW, default 32, data width (multiple of 8); BW=DW/8 byte lanes.
REQ-004 SHALL have ports:
  clk  input  1  clock, all state on rising edge.
  reset  input  1  asynchronous, active-low reset.
  adr  input  AW  CPU write word address.
  data  input  DW  CPU write data.
  byteen  input  BW  CPU byte enables, bit i = lane data[8i+7:8i].
  en  input  1  CPU write request.
  done  output  1  buffer can take the request this cycle.
  flush  input  1  block new accepts until drained.
  radr  input  AW  snoop/forward lookup address.
  rhit  output  1  some valid entry matches radr.
  rdata  output  DW  forwarded bytes for radr.
  rbyteen  output  BW  lanes valid in rdata.
  memadr  output  AW  head-entry address to memory.
  memdata  output  DW  head-entry data.
  membyteen  output  BW  head-entry byte enables.
  memen  output  1  memory write request.
  memdone  input  1  memory accepted the current request.
  empty  output  1  no valid entries.
  count  output  clog2(DEPTH)+1  valid entry count.

Function
REQ-005 SHALL hold a circular FIFO of DEPTH entries {adr, data, byteen}, with head and tail pointers wrapping modulo DEPTH.
REQ-006 Accept = en & done at a rising edge; the CPU SHALL hold adr/data/byteen stable while en=1 & done=0.
REQ-007 Merge condition: count>=2 & adr==tail-entry adr. The head entry SHALL never be a merge target.
REQ-008 done SHALL be combinational: ~flush & ~(count==DEPTH & ~merge condition). It SHALL NOT depend on memdone, so no push-through when full.
REQ-009 Accept with merge: tail lanes with byteen=1 SHALL take the new data, tail byteen |= byteen, count unchanged.
REQ-010 Accept without merge: a new tail entry SHALL be allocated, tail+1, count+1.
REQ-011 Accept with byteen==0: SHALL be acknowledged (done as per REQ-008) with no state change.
REQ-012 memen SHALL equal ~empty; memadr/memdata/membyteen SHALL equal head-entry fields and stay stable while memen=1 until memdone.
REQ-013 Pop: memen & memdone at a rising edge SHALL invalidate the head, head+1, count-1. The next entry SHALL be presented the following cycle with no bubble.
REQ-014 Latency: a write accepted into an empty buffer SHALL assert memen in the next cycle.
REQ-015 Simultaneous push (alloc) and pop SHALL leave count unchanged. Simultaneous merge and pop SHALL give count-1. The pop target and merge target never coincide (REQ-007).
REQ-016 Forwarding (combinational): rhit = OR over valid entries of adr==radr.
  rbyteen = OR of matching byteen.
  Each rdata lane SHALL come from the newest matching entry enabling that lane.
  Unenabled lanes SHALL be 0.
REQ-017 With flush=1: done=0, draining continues; empty=1 once count==0.
REQ-018 count SHALL never exceed DEPTH or underflow; memdone while memen=0 SHALL be ignored.

Reset
REQ-019 reset=0 SHALL immediately clear all entries and set head=tail=0, count=0, empty=1, memen=0, rhit=0, rbyteen=0, rdata=0, and done=~flush.
REQ-020 Reset during an outstanding memory write SHALL abandon the write; no entry survives.

Verification
REQ-021 Empty buffer, write adr=0x4AD, data=0xDDCCBBAA, byteen=1111 -> next cycle memen=1, memadr=0x4AD, memdata=0xDDCCBBAA; memdone=1 one cycle -> empty=1, count=0.
REQ-022 memdone held 0, DEPTH=4:
  - write A=0x10, then B=0x20 (byteen=0011, data=0x00001111).
  - then B again (byteen=1100, data=0x22220000).
  -> count=2, tail data 0x22221111, byteen=1111.
  - write A again -> new entry, count=3 (A is the head, not merged).
REQ-023 Fill 4 distinct addresses, memdone=0 -> done=0 on a fifth distinct address, but done=1 for the tail's address (merge); pulse memdone -> done=1 next cycle.
REQ-024 Entries {0x30, byteen=0001, 0x000000AA}, {0x40}, {0x30, byteen=0011, 0x0000BBCC}; radr=0x30 -> rhit=1, rbyteen=0011, rdata=0x0000BBCC; radr=0x50 -> rhit=0, rdata=0.
REQ-025 Three entries queued, memen=1, assert reset=0 mid-cycle -> memen, count, and rhit drop to 0 without a clock edge; after release, empty=1 and done=1.
REQ-026 flush=1 with 2 entries -> done=0 throughout, 2 pops, then empty=1; byteen=0 write with flush=0 -> done=1, count unchanged.

Source files
------------

// File: rtl/coalescing_write_buffer.sv
// rtl/coalescing_write_buffer.sv - circular write buffer that merges writes to the newest entry and forwards bytes
module coalescing_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 30,
  parameter int DW    = 32,
  localparam int BW   = DW / 8,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] data,
  input  logic [BW-1:0] byteen,
  input  logic          en,
  output logic          done,
  input  logic          flush,
  input  logic [AW-1:0] radr,
  output logic          rhit,
  output logic [DW-1:0] rdata,
  output logic [BW-1:0] rbyteen,
  output logic [AW-1:0] memadr,
  output logic [DW-1:0] memdata,
  output logic [BW-1:0] membyteen,
  output logic          memen,
  input  logic          memdone,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] ent_adr  [DEPTH];
  logic [DW-1:0] ent_data [DEPTH];
  logic [BW-1:0] ent_be   [DEPTH];
  logic [PW-1:0] head, tail, last;
  logic          merge, accept, do_merge, do_alloc, pop;

  // The head may be in flight to memory, so merging needs at least two entries.
  assign last     = tail - PW'(1);
  assign merge    = (count >= CW'(2)) && (ent_adr[last] == adr);
  assign done     = ~flush & ~((count == CW'(DEPTH)) & ~merge);
  assign accept   = en & done & (|byteen);
  assign do_merge = accept & merge;
  assign do_alloc = accept & ~merge;
  assign pop      = memen & memdone;

  assign memen     = (count != '0);
  assign empty     = (count == '0);
  assign memadr    = ent_adr[head];
  assign memdata   = ent_data[head];
  assign membyteen = ent_be[head];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_adr[i]  <= '0;
        ent_data[i] <= '0;
        ent_be[i]   <= '0;
      end
    end else begin
      if (do_alloc) begin
        ent_adr[tail]  <= adr;
        ent_data[tail] <= data;
        ent_be[tail]   <= byteen;
        tail           <= tail + PW'(1);
      end
      if (do_merge) begin
        for (int l = 0; l < BW; l++)
          if (byteen[l]) ent_data[last][8*l +: 8] <= data[8*l +: 8];
        ent_be[last] <= ent_be[last] | byteen;
      end
      if (pop) head <= head + PW'(1);
      count <= count + CW'(do_alloc) - CW'(pop);
    end
  end

  // Walk oldest to newest so a newer matching entry overrides each lane it enables.
  always_comb begin
    rhit    = 1'b0;
    rbyteen = '0;
    rdata   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (ent_adr[head + PW'(i)] == radr)) begin
        rhit    = 1'b1;
        rbyteen = rbyteen | ent_be[head + PW'(i)];
        for (int l = 0; l < BW; l++)
          if (ent_be[head + PW'(i)][l])
            rdata[8*l +: 8] = ent_data[head + PW'(i)][8*l +: 8];
      end
    end
  end

endmodule
